ifetch_unit: RTL and testbench

- Instruction-fetch and next-PC block for the SimpleCPU datapath.
- Owns the PC register and fetches words from instruction memory over a req/ack handshake.
- Presents each fetched instruction to the decode stage (the CU) over a valid/ready handshake.
- Applies the CU's Branch code and PCtoReg to choose the next PC, and supplies the link address for jal.

---
 rtl/ifetch_unit.sv | 99 +++++++++
 tb/tb_ifetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch and next-PC unit: owns the PC, fetches over req/ack, holds the word for decode.
// Optional retire counter output enabled by defining IFETCH_RETIRE_COUNT_EN.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   input  logic [1:0]  branch,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] rs_data,
`ifdef IFETCH_RETIRE_COUNT_EN
   output logic [31:0] retire_cnt,
`endif
   output logic        misalign
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]  state;
   logic [31:0] p4;
   logic [31:0] next_pc;
   logic        accept;
   logic        jr_fault;

   assign imem_req   = (state == S_FETCH);
   assign inst_valid = (state == S_HOLD);
   assign misalign   = (state == S_HALT);
   assign imem_addr  = pc;
   assign p4         = pc + 32'd4;
   assign link_addr  = p4;
   assign accept     = inst_valid && inst_ready;
   assign jr_fault   = (branch == 2'b11) && (rs_data[1:0] != 2'b00);

   // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      next_pc = p4;
      case (branch)
         2'b00:   next_pc = p4;
         2'b01:   next_pc = p4 + {{14{imm16[15]}}, imm16, 2'b00};
         2'b10:   next_pc = {p4[31:28], target26, 2'b00};
         default: next_pc = rs_data;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         inst  <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (imem_ack) begin
                  inst  <= imem_rdata;
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               // A misaligned jr target is never loaded into pc, so it is never fetched.
               if (inst_ready) begin
                  if (jr_fault) begin
                     state <= S_HALT;
                  end else begin
                     pc    <= next_pc;
                     state <= S_FETCH;
                  end
               end
            end
            default: state <= S_HALT;
         endcase
      end
   end

`ifdef IFETCH_RETIRE_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if (accept) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus pushes expected fetches/accepts, a monitor pops and compares.
module tb_ifetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic [1:0]  branch = 2'b00;
   logic [15:0] imm16 = '0;
   logic [25:0] target26 = '0;
   logic [31:0] rs_data = '0;
   logic        misalign;
`ifdef IFETCH_RETIRE_COUNT_EN
   logic [31:0] retire_cnt;
`endif

   int passed = 0;
   int total = 0;
   int cyc = 0;
   int accepts = 0;
   logic [31:0] addr_q[$];
   exp_t        inst_q[$];
   logic [31:0] mon_addr;
   exp_t        mon_exp;

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc), .link_addr(link_addr),
      .branch(branch), .imm16(imm16), .target26(target26), .rs_data(rs_data),
`ifdef IFETCH_RETIRE_COUNT_EN
      .retire_cnt(retire_cnt),
`endif
      .misalign(misalign)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Monitor: compares every handshake the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst) begin
         check("req_valid_exclusive", 32'(imem_req & inst_valid), 32'd0);
         if (imem_req && imem_ack) begin
            if (addr_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_fetch: got addr %h required no fetch", imem_addr);
            end else begin
               mon_addr = addr_q.pop_front();
               check("fetch_addr", imem_addr, mon_addr);
            end
         end
         if (inst_valid && inst_ready) begin
            if (inst_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_accept: got pc %h required no accept", pc);
            end else begin
               mon_exp = inst_q.pop_front();
               check("accept_pc", pc, mon_exp.pc);
               check("accept_inst", inst, mon_exp.word);
               check("link_addr", link_addr, mon_exp.pc + 32'd4);
            end
         end
      end
   end

   task automatic check_reset_values();
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_imem_addr", imem_addr, 32'h0000_0000);
      check("rst_pc", pc, 32'h0000_0000);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'h0000_0000);
      check("rst_link_addr", link_addr, 32'h0000_0004);
      check("rst_misalign", 32'(misalign), 32'd0);
`ifdef IFETCH_RETIRE_COUNT_EN
      check("rst_retire_cnt", retire_cnt, 32'd0);
`endif
   endtask

   // Asserts rst mid-cycle, checks outputs in that same cycle, releases after the next edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_reset_values();
      @(posedge clk); #1;
      rst = 1'b0;
      imem_ack = 1'b0;
      accepts = 0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
   endtask

   task automatic fetch(input int delay, input logic [31:0] addr);
      addr_q.push_back(addr);
      wait_req();
      if (!imem_req) begin
         total++;
         $display("FAIL fetch_timeout: got imem_req=0 required 1 for addr %h", addr);
         return;
      end
      for (int i = 0; i < delay; i++) begin
         check("stall_req", 32'(imem_req), 32'd1);
         check("stall_addr", imem_addr, addr);
         @(posedge clk); #1;
      end
      imem_ack = 1'b1;
      imem_rdata = mem_word(addr);
      @(posedge clk); #1;
      imem_ack = 1'b0;
      imem_rdata = '0;
      check("no_double_fetch", 32'(imem_req), 32'd0);
   endtask

   task automatic accept(input int delay, input logic [1:0] br, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] rs, input logic [31:0] exp_pc);
      int n = 0;
      inst_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
      while (!inst_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!inst_valid) begin
         total++;
         $display("FAIL accept_timeout: got inst_valid=0 required 1 for pc %h", exp_pc);
         return;
      end
      for (int i = 0; i < delay; i++) begin
         check("hold_inst", inst, mem_word(exp_pc));
         check("hold_pc", pc, exp_pc);
         check("hold_valid", 32'(inst_valid), 32'd1);
         @(posedge clk); #1;
      end
      branch = br; imm16 = imm; target26 = tgt; rs_data = rs;
      inst_ready = 1'b1;
      @(posedge clk); #1;
      inst_ready = 1'b0;
      branch = 2'b00; imm16 = '0; target26 = '0; rs_data = '0;
      accepts++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish required finish within budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      do_reset();

      // Sequential zero-wait fetch: two cycles per instruction.
      wait_req();
      start = cyc;
      fetch(0, 32'h0000_0000); accept(0, 2'b00, '0, '0, '0, 32'h0000_0000);
      fetch(0, 32'h0000_0004); accept(0, 2'b00, '0, '0, '0, 32'h0000_0004);
      fetch(0, 32'h0000_0008); accept(0, 2'b00, '0, '0, '0, 32'h0000_0008);
      check("cycles_for_three", 32'(cyc - start), 32'd6);

      // Taken backward branch from 0x10.
      fetch(0, 32'h0000_000C); accept(0, 2'b00, '0, '0, '0, 32'h0000_000C);
      fetch(0, 32'h0000_0010); accept(0, 2'b01, 16'hFFFE, '0, '0, 32'h0000_0010);

      // jr to 0x9000_0010, j with target26=0x40, jr to top of memory, sequential wrap.
      fetch(0, 32'h0000_000C); accept(0, 2'b11, '0, '0, 32'h9000_0010, 32'h0000_000C);
      fetch(0, 32'h9000_0010); accept(0, 2'b10, '0, 26'h40, '0, 32'h9000_0010);
      fetch(0, 32'h9000_0100); accept(0, 2'b11, '0, '0, 32'hFFFF_FFFC, 32'h9000_0100);
      fetch(0, 32'hFFFF_FFFC); accept(0, 2'b00, '0, '0, '0, 32'hFFFF_FFFC);

      // Memory stall of 3 cycles, decode stall of 2 cycles.
      fetch(3, 32'h0000_0000); accept(2, 2'b00, '0, '0, '0, 32'h0000_0000);

      // Aligned jr proceeds; misaligned jr halts with pc on the jr.
      fetch(0, 32'h0000_0004); accept(0, 2'b11, '0, '0, 32'h0000_0200, 32'h0000_0004);
      fetch(0, 32'h0000_0200); accept(0, 2'b11, '0, '0, 32'h0000_0102, 32'h0000_0200);
      imem_ack = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("halt_misalign", 32'(misalign), 32'd1);
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_valid", 32'(inst_valid), 32'd0);
         check("halt_pc", pc, 32'h0000_0200);
         check("halt_link", link_addr, 32'h0000_0204);
         @(posedge clk); #1;
      end
      inst_ready = 1'b0;
`ifdef IFETCH_RETIRE_COUNT_EN
      check("retire_before_halt_reset", retire_cnt, 32'(accepts));
`endif

      // Reset out of HALT with ack held high, then reset in FETCH and in HOLD.
      do_reset();
      wait_req();
      check("fetch_before_pulse", 32'(imem_req), 32'd1);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      do_reset();
      imem_rdata = '0;
      fetch(0, 32'h0000_0000); accept(0, 2'b00, '0, '0, '0, 32'h0000_0000);
      fetch(0, 32'h0000_0004);
      check("hold_before_pulse", 32'(inst_valid), 32'd1);
      do_reset();

      // Three accepts then reset clears the retire counter.
      fetch(0, 32'h0000_0000); accept(0, 2'b00, '0, '0, '0, 32'h0000_0000);
      fetch(0, 32'h0000_0004); accept(0, 2'b00, '0, '0, '0, 32'h0000_0004);
      fetch(0, 32'h0000_0008); accept(0, 2'b00, '0, '0, '0, 32'h0000_0008);
`ifdef IFETCH_RETIRE_COUNT_EN
      check("retire_three", retire_cnt, 32'd3);
`endif
      do_reset();
      fetch(0, 32'h0000_0000);

      @(negedge clk);
      check("addr_q_drained", 32'(addr_q.size()), 32'd0);
      check("inst_q_drained", 32'(inst_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
